sbox_ctr_stream_cipher_mp: RTL

Parametrised, multi-lane successor to the single-byte S-box counter-mode stream cipher. Each accepted beat carries LANES bytes; each byte is XORed with an AES S-box keystream byte derived from an 8-bit running counter seeded by the symmetric key. Full valid/ready handshaking on both sides, an output buffer for backpressure, and explicit message framing (key load / last beat). Sits between the byte-stream source and the link/packer stage.

---
 rtl/sbox_ctr_stream_cipher_mp_if.sv | 36 +++
 rtl/sbox_ctr_stream_cipher_mp.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sbox_ctr_stream_cipher_mp_if.sv
// Beat-stream bundle for the multi-lane S-box counter-mode cipher.
// The bypass signal exists only when CIPHER_BYPASS_EN is defined.
interface sbox_ctr_stream_cipher_mp_if #(
   parameter int LANES = 4
);
   logic                 key_load;
   logic [7:0]           simmetric_key;
   logic                 din_valid;
   logic                 din_ready;
   logic [8*LANES-1:0]   din_data;
   logic                 din_last;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [8*LANES-1:0]   dout_data;
   logic                 dout_last;
   logic                 busy;
`ifdef CIPHER_BYPASS_EN
   logic                 bypass;
`endif

   modport master (
`ifdef CIPHER_BYPASS_EN
      output bypass,
`endif
      output key_load, simmetric_key, din_valid, din_data, din_last, dout_ready,
      input  din_ready, dout_valid, dout_data, dout_last, busy
   );

   modport slave (
`ifdef CIPHER_BYPASS_EN
      input  bypass,
`endif
      input  key_load, simmetric_key, din_valid, din_data, din_last, dout_ready,
      output din_ready, dout_valid, dout_data, dout_last, busy
   );
endinterface

// File: rtl/sbox_ctr_stream_cipher_mp.sv
// Multi-lane AES S-box counter-mode stream cipher with framed input and a small output FIFO.
// Optional per-beat plaintext bypass is enabled with `define CIPHER_BYPASS_EN.

module sbox_lut (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   assign s_o = SBOX[a_i];
endmodule

// state | meaning
// IDLE  | no message open, input closed, waiting for key_load
// RUN   | message open, beats accepted while the output FIFO has room
module sbox_ctr_stream_cipher_mp #(
   parameter int LANES      = 4,
   parameter int OBUF_DEPTH = 2
) (
   input logic                          clk,
   input logic                          rst_n,
   sbox_ctr_stream_cipher_mp_if.slave   bus
);
   localparam int W  = 8*LANES;
   localparam int AW = $clog2(OBUF_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q;
   logic [7:0]      ctr_q;
   logic [W-1:0]    mem_q      [OBUF_DEPTH];
   logic            mem_last_q [OBUF_DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     cnt_q;
   logic [W-1:0]    hold_data_q;
   logic            hold_last_q;

   logic [W-1:0]    ks;
   logic [W-1:0]    enc_data;
   logic            full, empty, push, pop, bypass_s, din_ready_s;

   assign full        = (cnt_q == (AW+1)'(OBUF_DEPTH));
   assign empty       = (cnt_q == '0);
   assign din_ready_s = (state_q == RUN) && !full;
   assign push        = bus.din_valid && din_ready_s;
   assign pop         = !empty && bus.dout_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lut u_sbox (
         .a_i (ctr_q + 8'(i)),
         .s_o (ks[8*i +: 8])
      );
   end

`ifdef CIPHER_BYPASS_EN
   assign bypass_s = bus.bypass;
`else
   assign bypass_s = 1'b0;
`endif

   assign enc_data = bus.din_data ^ (bypass_s ? '0 : ks);

   // key_load is applied last so it overrides both the increment and a closing din_last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctr_q   <= 8'h00;
      end else begin
         case (state_q)
            IDLE: ;
            RUN: begin
               if (push) begin
                  if (!bypass_s) ctr_q <= ctr_q + 8'(LANES);
                  if (bus.din_last) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (bus.key_load) begin
            ctr_q   <= bus.simmetric_key;
            state_q <= RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            mem_q[i]      <= '0;
            mem_last_q[i] <= 1'b0;
         end
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         hold_data_q <= '0;
         hold_last_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wptr_q]      <= enc_data;
            mem_last_q[wptr_q] <= bus.din_last;
            wptr_q             <= wptr_q + AW'(1);
         end
         if (pop) begin
            hold_data_q <= mem_q[rptr_q];
            hold_last_q <= mem_last_q[rptr_q];
            rptr_q      <= rptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // An empty FIFO keeps presenting the most recently popped beat
   assign bus.din_ready  = din_ready_s;
   assign bus.dout_valid = !empty;
   assign bus.dout_data  = empty ? hold_data_q : mem_q[rptr_q];
   assign bus.dout_last  = empty ? hold_last_q : mem_last_q[rptr_q];
   assign bus.busy       = (state_q == RUN) || !empty;

endmodule
